// File: rtl/mem_control_pkg.sv
// Shared types and default sizing for the zero-initialising memory controller.
package mem_control_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_RD_LAT = 1;

endpackage

// File: rtl/mem_rd_pipe.sv
// Read-response delay line: carries valid, error and data flags RD_LAT stages.
// in_data is the RAM output register, so it already sits one stage along.
module mem_rd_pipe #(
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_err,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic              out_err,
    output logic [DATA_W-1:0] out_data
);

    logic [RD_LAT-1:0] valid_reg;
    logic [RD_LAT-1:0] err_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_reg <= '0;
            err_reg   <= '0;
        end else begin
            valid_reg[0] <= in_valid;
            err_reg[0]   <= in_err;
            for (int i = 1; i < RD_LAT; i++) begin
                valid_reg[i] <= valid_reg[i-1];
                err_reg[i]   <= err_reg[i-1];
            end
        end
    end

    assign out_valid = valid_reg[RD_LAT-1];
    assign out_err   = err_reg[RD_LAT-1];

    generate
        if (RD_LAT == 1) begin : g_direct
            assign out_data = in_data;
        end else begin : g_delay
            logic [DATA_W-1:0] data_reg [RD_LAT-1];

            // Data needs no reset: it is masked by valid at the top level.
            always_ff @(posedge clk) begin
                data_reg[0] <= in_data;
                for (int i = 1; i < RD_LAT - 1; i++) begin
                    data_reg[i] <= data_reg[i-1];
                end
            end

            assign out_data = data_reg[RD_LAT-2];
        end
    endgenerate

endmodule

// File: rtl/mem_control_p.sv
// Single-port memory controller: clears every word after reset, then serves
// read-before-write accesses with a fixed read latency and range checking.
module mem_control_p
    import mem_control_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = 2**ADDR_W,
    parameter int RD_LAT = DEF_RD_LAT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              read_en,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic [DATA_W-1:0] rdata,
    output logic              rd_valid,
    output logic              addr_err
);

    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] init_ptr_reg, init_ptr_next;
    logic              wr_err_reg;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] mem_q;

    logic              in_range;
    logic              rd_acc;
    logic              wr_acc;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [DATA_W-1:0] mem_wd;
    logic [ADDR_W-1:0] rd_idx;

    logic              pipe_valid;
    logic              pipe_err;
    logic [DATA_W-1:0] pipe_data;

    assign in_range = {1'b0, addr} < DEPTH_EXT;
    assign ready    = (state_reg == RUN);
    assign rd_acc   = ready && read_en;
    assign wr_acc   = ready && write_en;
    // Out-of-range reads still need a legal RAM index; the result is masked.
    assign rd_idx   = in_range ? addr : '0;

    always_comb begin
        state_next    = state_reg;
        init_ptr_next = init_ptr_reg;
        mem_we        = 1'b0;
        mem_wa        = addr;
        mem_wd        = wdata;
        case (state_reg)
            INIT: begin
                mem_we        = 1'b1;
                mem_wa        = init_ptr_reg;
                mem_wd        = '0;
                init_ptr_next = init_ptr_reg + ADDR_W'(1);
                if (init_ptr_reg == LAST_ADDR) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                mem_we = wr_acc && in_range;
            end
            default: begin
                state_next = INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= INIT;
            init_ptr_reg <= '0;
            wr_err_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            init_ptr_reg <= init_ptr_next;
            wr_err_reg   <= wr_acc && !in_range;
        end
    end

    // Read-first RAM: the registered read sees the word before this edge's write.
    always_ff @(posedge clk) begin
        if (mem_we && rst_n) begin
            mem[mem_wa] <= mem_wd;
        end
        mem_q <= mem[rd_idx];
    end

    mem_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (rd_acc),
        .in_err    (rd_acc && !in_range),
        .in_data   (mem_q),
        .out_valid (pipe_valid),
        .out_err   (pipe_err),
        .out_data  (pipe_data)
    );

    assign rd_valid = pipe_valid;
    assign rdata    = (pipe_valid && !pipe_err) ? pipe_data : '0;
    assign addr_err = (pipe_valid && pipe_err) || wr_err_reg;

endmodule

// File: tb/tb_mem_control_p.sv
// Scoreboard bench: two controller instances (full depth / latency 1, depth 200 / latency 3)
// share one random stimulus stream, checked against a behavioural memory model.
module tb_mem_control_p;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       read_en;
    logic       write_en;
    logic [7:0] addr;
    logic [7:0] wdata;

    logic       ready    [2];
    logic [7:0] rdata    [2];
    logic       rd_valid [2];
    logic       addr_err [2];

    typedef struct {
        logic [7:0] data;
        logic       err;
        int         due;
    } rsp_t;

    rsp_t       rq [2][$];
    int         wq [2][$];
    logic [7:0] mem_m [2][256];
    int         depth_m [2] = '{256, 200};
    int         lat_m   [2] = '{1, 3};

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    logic mon_on = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_control_p #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .RD_LAT(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .read_en(read_en), .write_en(write_en),
        .addr(addr), .wdata(wdata), .ready(ready[0]), .rdata(rdata[0]),
        .rd_valid(rd_valid[0]), .addr_err(addr_err[0])
    );

    mem_control_p #(.ADDR_W(8), .DATA_W(8), .DEPTH(200), .RD_LAT(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .read_en(read_en), .write_en(write_en),
        .addr(addr), .wdata(wdata), .ready(ready[1]), .rdata(rdata[1]),
        .rd_valid(rd_valid[1]), .addr_err(addr_err[1])
    );

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d cycle %0d: got %0h expected %0h", nm, k, cyc, act, exp);
        end
    endtask

    // Reference behaviour of one accepted cycle for instance k at edge e.
    task automatic model_accept(input int k, input logic rd, input logic wr,
                                input logic [7:0] a, input logic [7:0] d, input int e);
        rsp_t r;
        if (rd) begin
            r.err  = (int'(a) >= depth_m[k]);
            r.data = r.err ? 8'h00 : mem_m[k][a];
            r.due  = e + lat_m[k] - 1;
            rq[k].push_back(r);
        end
        if (wr) begin
            if (int'(a) < depth_m[k]) mem_m[k][a] = d;
            else wq[k].push_back(e);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d);
        read_en  = rd;
        write_en = wr;
        addr     = a;
        wdata    = d;
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) model_accept(k, rd, wr, a, d, cyc);
        $display("req cycle %0d rd=%0b wr=%0b addr=%0d wdata=%02h", cyc, rd, wr, a, d);
    endtask

    task automatic idle(input int n);
        read_en  = 1'b0;
        write_en = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_ready();
        int first [2];
        first = '{-1, -1};
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (i == 0) chk("ready_after_reset", k, ready[k], 0);
                if (ready[k] && first[k] < 0) first[k] = i;
            end
            if (first[0] >= 0 && first[1] >= 0) break;
        end
        for (int k = 0; k < 2; k++) chk("init_cycles", k, first[k], depth_m[k]);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        read_en  = 1'b0;
        write_en = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk);
        #1;
        mon_on = 1'b1;
        for (int k = 0; k < 2; k++) begin
            rq[k].delete();
            wq[k].delete();
            for (int j = 0; j < 256; j++) mem_m[k][j] = 8'h00;
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_ready();
    endtask

    task automatic random_ops(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  8'($urandom_range(0, 255)), 8'($urandom));
        end
        idle(4);
    endtask

    // Monitor: every cycle, match DUT responses against the expected queues.
    always @(negedge clk) begin
        if (mon_on) begin
            for (int k = 0; k < 2; k++) begin
                logic exp_err;
                rsp_t r;
                exp_err = 1'b0;
                if (wq[k].size() > 0 && wq[k][0] <= cyc) begin
                    exp_err = 1'b1;
                    void'(wq[k].pop_front());
                end
                if (rd_valid[k]) begin
                    if (rq[k].size() == 0) begin
                        chk("rd_valid_unexpected", k, rd_valid[k], 0);
                    end else begin
                        r = rq[k].pop_front();
                        chk("latency", k, cyc, r.due);
                        chk("rdata", k, rdata[k], r.data);
                        exp_err = exp_err | r.err;
                        $display("rsp inst%0d cycle %0d rdata=%02h addr_err=%0b", k, cyc, rdata[k], addr_err[k]);
                    end
                end else begin
                    chk("rdata_idle", k, rdata[k], 0);
                    if (rq[k].size() > 0 && rq[k][0].due <= cyc) begin
                        chk("rd_valid_missing", k, rd_valid[k], 1);
                        void'(rq[k].pop_front());
                    end
                end
                chk("addr_err", k, addr_err[k], exp_err);
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        read_en  = 1'b0;
        write_en = 1'b0;
        addr     = '0;
        wdata    = '0;
        do_reset();

        drive(1, 0, 8'd2, 8'h00);
        idle(1);
        drive(0, 1, 8'd11, 8'hA5);
        drive(1, 0, 8'd11, 8'h00);
        idle(4);
        drive(1, 0, 8'd2, 8'h00);
        drive(1, 0, 8'd11, 8'h00);
        drive(1, 0, 8'd1, 8'h00);
        drive(1, 0, 8'd13, 8'h00);
        idle(4);
        drive(1, 1, 8'd13, 8'h3C);
        drive(1, 0, 8'd13, 8'h00);
        idle(4);
        drive(1, 0, 8'd250, 8'h00);
        drive(0, 1, 8'd250, 8'h77);
        idle(1);
        drive(1, 0, 8'd250, 8'h00);
        drive(1, 0, 8'd50, 8'h00);
        drive(1, 0, 8'd122, 8'h00);
        idle(4);

        random_ops(400);

        drive(0, 1, 8'd11, 8'h5A);
        drive(1, 0, 8'd11, 8'h00);
        drive(1, 0, 8'd13, 8'h00);
        do_reset();
        drive(1, 0, 8'd11, 8'h00);
        drive(1, 0, 8'd250, 8'h00);
        random_ops(100);
        idle(8);

        for (int k = 0; k < 2; k++) chk("queue_drained", k, rq[k].size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_control_p.md
MEM_CONTROL_P -- requirements
Module: mem_control_p

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, address width in bits.
REQ-002 SHALL have parameter DATA_W, default 8, data word width in bits.
REQ-003 SHALL have parameter DEPTH, default 2**ADDR_W, number of implemented words; legal range 2..2**ADDR_W.
REQ-004 SHALL have parameter RD_LAT, default 1, read latency in cycles; legal values 1..4.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset; synchronous and active-low.
REQ-007 SHALL have port read_en, input, 1, read request, level-sampled each cycle.
REQ-008 SHALL have port write_en, input, 1, write request, level-sampled each cycle.
REQ-009 SHALL have port addr, input, ADDR_W, word address for read and write.
REQ-010 SHALL have port wdata, input, DATA_W, write data.
REQ-011 SHALL have port ready, output, 1, high when requests are accepted.
REQ-012 SHALL have port rdata, output, DATA_W, read data, valid only while rd_valid=1.
REQ-013 SHALL have port rd_valid, output, 1, one-cycle pulse per accepted read.
REQ-014 SHALL have port addr_err, output, 1, one-cycle pulse marking an out-of-range access response.

Function
REQ-015 SHALL implement a two-state FSM: INIT and RUN.
REQ-016 In INIT, SHALL write 0 to one word per cycle, addresses 0..DEPTH-1 in order, with ready=0; after writing DEPTH-1, SHALL go to RUN on the next edge.
REQ-017 In RUN, ready=1; SHALL remain in RUN until reset.
REQ-018 In INIT, read_en and write_en SHALL be ignored.
REQ-019 A read is accepted when ready=1 and read_en=1; one read per cycle, with no back-pressure.
REQ-020 For a read accepted at edge N, rd_valid=1 and rdata SHALL appear in the cycle after edge N+RD_LAT-1, i.e. exactly RD_LAT cycles later; reads are delivered in order.
REQ-021 A write is accepted when ready=1 and write_en=1; memory is updated at that edge.
REQ-022 If read and write are accepted in the same cycle (one shared addr), the read SHALL return the pre-write data (read-before-write), and the write SHALL still complete.
REQ-023 A later read of an address written in an earlier cycle SHALL return the new data, whatever RD_LAT is.
REQ-024 For an access with addr >= DEPTH: a write SHALL be dropped; a read SHALL return rdata=0 with rd_valid=1 and addr_err=1 in the response cycle.
REQ-025 A dropped out-of-range write SHALL pulse addr_err the cycle after acceptance; if a read response falls in the same cycle, addr_err is the OR of both.
REQ-026 When rd_valid=0, rdata SHALL be 0.
REQ-027 read_en or write_en held high for K cycles SHALL produce K accepted operations; there is no edge detection.

Reset
REQ-028 When rst_n=0 at an edge: state=INIT, init pointer=0, read pipeline flushed; ready, rd_valid, addr_err and rdata SHALL be 0 the next cycle.
REQ-029 Reset mid-INIT or mid-RUN SHALL drop all in-flight reads (no rd_valid after reset) and restart INIT from address 0.
REQ-030 Memory contents SHALL be defined only through INIT, not by the reset itself.

Structure
REQ-031 Package mem_control_pkg SHALL hold the FSM state enum (INIT, RUN) and the default parameter constants.
REQ-032 The read-latency delay line (valid, err, data; RD_LAT stages) SHALL be sub-module mem_rd_pipe; everything else stays in mem_control_p.

Verification
REQ-033 Reset for 2 cycles with defaults -> ready=0 for exactly 256 cycles after rst_n rises, then ready=1; read addr 2 -> rdata=0x00.
REQ-034 Write 0xA5 to addr 11, then read addr 11 the next cycle, RD_LAT=1 and RD_LAT=3 -> rdata=0xA5 with rd_valid exactly 1 and 3 cycles after the read.
REQ-035 read_en held for 4 cycles with addr 2, 11, 1, 13 -> 4 rd_valid pulses, data in the same order.
REQ-036 Same cycle read+write addr 13, old 0x00, new 0x3C -> that read returns 0x00; the next read returns 0x3C.
REQ-037 DEPTH=200, read addr 250 -> rdata=0, rd_valid=1, addr_err=1; write addr 250 -> addr_err pulse, memory unchanged.
REQ-038 Assert rst_n=0 with 2 reads in flight (RD_LAT=3) -> no rd_valid afterwards; INIT restarts at address 0.
